// File: rtl/snake_pkg.sv
// Shared types and constants for the snake motion block: direction encoding,
// PS/2 make codes, playfield geometry and the spawn position.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam logic [7:0] KEY_UP    = 8'h1D;
    localparam logic [7:0] KEY_RIGHT = 8'h23;
    localparam logic [7:0] KEY_DOWN  = 8'h1B;
    localparam logic [7:0] KEY_LEFT  = 8'h1C;

    localparam int DEF_GRID_W  = 40;
    localparam int DEF_GRID_H  = 30;
    localparam int DEF_MAX_LEN = 16;

    localparam int X_W   = 6;
    localparam int Y_W   = 5;
    localparam int LEN_W = 5;

    localparam logic [X_W-1:0]   INIT_X   = 6'd20;
    localparam logic [Y_W-1:0]   INIT_Y   = 5'd15;
    localparam logic [LEN_W-1:0] INIT_LEN = 5'd3;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pos_t;

    // Opposite directions differ only in the upper encoding bit.
    function automatic logic is_opposite(input dir_t a, input dir_t b);
        return (a ^ b) == 2'd2;
    endfunction

endpackage

// File: rtl/snake_key_decode.sv
// Maps a qualified PS/2 make code onto a movement direction; unknown codes
// produce no direction.
module snake_key_decode
    import snake_pkg::*;
(
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       dir_valid,
    output dir_t       dir
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        dir_valid = 1'b0;
        dir       = DIR_UP;
        if (key_valid) begin
            case (key_code)
                KEY_UP:    begin dir_valid = 1'b1; dir = DIR_UP;    end
                KEY_RIGHT: begin dir_valid = 1'b1; dir = DIR_RIGHT; end
                KEY_DOWN:  begin dir_valid = 1'b1; dir = DIR_DOWN;  end
                KEY_LEFT:  begin dir_valid = 1'b1; dir = DIR_LEFT;  end
                default:   ;
            endcase
        end
    end

endmodule

// File: rtl/snake_motion.sv
// Snake body store and motion engine: paced steps, steering, growth,
// wall/self collision detection and a cell-occupancy query for the renderer.
module snake_motion
    import snake_pkg::*;
#(
    parameter int GRID_W   = DEF_GRID_W,
    parameter int GRID_H   = DEF_GRID_H,
    parameter int MAX_LEN  = DEF_MAX_LEN,
    parameter int TICK_DIV = 12500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_snake,
    input  logic             screen_pause,
    input  logic             key_valid,
    input  logic [7:0]       key_code,
    input  logic             grow,
    input  logic [X_W-1:0]   query_x,
    input  logic [Y_W-1:0]   query_y,
    output logic             query_hit,
    output logic [X_W-1:0]   head_x,
    output logic [Y_W-1:0]   head_y,
    output logic [LEN_W-1:0] length,
    output logic             move_tick,
    output logic             died
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    pos_t             seg [MAX_LEN];
    dir_t             last_dir;
    dir_t             pending_dir;
    dir_t             key_dir;
    dir_t             ref_dir;
    logic [CNT_W-1:0] tick_cnt;
    logic             dead;
    logic             grow_pending;
    logic             dir_valid;
    logic             active;
    logic             step;
    logic             grow_eff;
    logic             wall_hit;
    logic             self_hit;
    logic             collide;
    logic [LEN_W-1:0] tail_idx;
    pos_t             next_pos;

    snake_key_decode u_key_decode (
        .key_valid (key_valid),
        .key_code  (key_code),
        .dir_valid (dir_valid),
        .dir       (key_dir)
    );

    assign active   = !screen_pause && !dead && !init_snake;
    assign step     = active && (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign grow_eff = grow_pending || grow;
    // During a step the reversal test is against the direction being committed now.
    assign ref_dir  = step ? pending_dir : last_dir;
    assign tail_idx = length - LEN_W'(1);
    assign head_x   = seg[0].x;
    assign head_y   = seg[0].y;
    assign collide  = wall_hit || self_hit;

    always_comb begin
        next_pos = seg[0];
        wall_hit = 1'b0;
        unique case (pending_dir)
            DIR_UP:    begin wall_hit = (seg[0].y == '0);                 next_pos.y = seg[0].y - Y_W'(1); end
            DIR_RIGHT: begin wall_hit = (seg[0].x == X_W'(GRID_W - 1));   next_pos.x = seg[0].x + X_W'(1); end
            DIR_DOWN:  begin wall_hit = (seg[0].y == Y_W'(GRID_H - 1));   next_pos.y = seg[0].y + Y_W'(1); end
            DIR_LEFT:  begin wall_hit = (seg[0].x == '0);                 next_pos.x = seg[0].x - X_W'(1); end
        endcase
    end

    // The tail vacates its cell on a plain step, so it only blocks when growing.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < tail_idx || (grow_eff && LEN_W'(i) == tail_idx)) && seg[i] == next_pos)
                self_hit = 1'b1;
        end
    end

    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < length && seg[i].x == query_x && seg[i].y == query_y)
                query_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || init_snake) begin
            // NOTE: the segment array is a small register file, so clearing it in reset is cheap and keeps it X-free.
            for (int i = 0; i < MAX_LEN; i++) begin
                seg[i] <= '0;
                if (i < 3) begin
                    seg[i].x <= INIT_X - X_W'(i);
                    seg[i].y <= INIT_Y;
                end
            end
            length       <= INIT_LEN;
            last_dir     <= DIR_RIGHT;
            pending_dir  <= DIR_RIGHT;
            tick_cnt     <= '0;
            dead         <= 1'b0;
            grow_pending <= 1'b0;
            died         <= 1'b0;
            move_tick    <= 1'b0;
        end else begin
            died      <= 1'b0;
            move_tick <= 1'b0;
            if (active)
                tick_cnt <= step ? '0 : tick_cnt + CNT_W'(1);
            if (dir_valid && !screen_pause && !dead && !is_opposite(key_dir, ref_dir))
                pending_dir <= key_dir;
            if (step) begin
                last_dir <= pending_dir;
                if (collide) begin
                    dead <= 1'b1;
                    died <= 1'b1;
                end else begin
                    move_tick <= 1'b1;
                    seg[0]    <= next_pos;
                    for (int i = 1; i < MAX_LEN; i++)
                        seg[i] <= seg[i-1];
                    if (grow_eff && length < LEN_W'(MAX_LEN))
                        length <= length + LEN_W'(1);
                end
            end
            if (step && !collide && grow_eff)
                grow_pending <= 1'b0;
            else if (grow)
                grow_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_snake_motion.sv
// Self-checking bench for snake_motion: directed scenarios followed by random
// play, all compared against a queue-based model of the snake.
module tb_snake_motion;

    localparam int TB_TICK = 4;
    localparam int GW      = 40;
    localparam int GH      = 30;
    localparam int TB_MAX  = 16;

    logic       clk;
    logic       rst_n;
    logic       init_snake;
    logic       screen_pause;
    logic       key_valid;
    logic [7:0] key_code;
    logic       grow;
    logic [5:0] query_x;
    logic [4:0] query_y;
    logic       query_hit;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [4:0] length;
    logic       move_tick;
    logic       died;

    snake_motion #(
        .GRID_W   (GW),
        .GRID_H   (GH),
        .MAX_LEN  (TB_MAX),
        .TICK_DIV (TB_TICK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_snake   (init_snake),
        .screen_pause (screen_pause),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .grow         (grow),
        .query_x      (query_x),
        .query_y      (query_y),
        .query_hit    (query_hit),
        .head_x       (head_x),
        .head_y       (head_y),
        .length       (length),
        .move_tick    (move_tick),
        .died         (died)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int x;
        int y;
    } pt_t;

    // Reference model: body[0] is the head, body.size() is the length.
    pt_t body[$];
    pt_t vac;
    bit  vac_ok;
    int  m_pend, m_last, m_cnt;
    bit  m_dead, m_gp, m_stepped;
    int  exp_died, exp_mt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int key_dir_of(input logic [7:0] code);
        case (code)
            8'h1D:   return 0;
            8'h23:   return 1;
            8'h1B:   return 2;
            8'h1C:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit model_hit(input int qx, input int qy);
        foreach (body[k])
            if (body[k].x == qx && body[k].y == qy) return 1'b1;
        return 1'b0;
    endfunction

    task automatic init_model();
        pt_t p;
        body.delete();
        for (int k = 0; k < 3; k++) begin
            p.x = 20 - k;
            p.y = 15;
            body.push_back(p);
        end
        m_pend = 1; m_last = 1; m_cnt = 0;
        m_dead = 0; m_gp = 0; vac_ok = 0;
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        int  kd, ref_dir, new_pend, nx, ny, lim;
        bit  act, stp, ge, hit, full;
        pt_t np;
        exp_died = 0; exp_mt = 0; m_stepped = 0;
        if (!rst_n || init_snake) begin
            init_model();
            return;
        end
        act      = !screen_pause && !m_dead;
        stp      = act && (m_cnt == TB_TICK - 1);
        ref_dir  = stp ? m_pend : m_last;
        new_pend = m_pend;
        kd       = key_dir_of(key_code);
        if (key_valid && !screen_pause && !m_dead && kd >= 0 && kd != (ref_dir + 2) % 4)
            new_pend = kd;
        if (act) m_cnt = stp ? 0 : m_cnt + 1;
        if (stp) begin
            m_stepped = 1;
            nx = body[0].x + ((m_pend == 1) ? 1 : (m_pend == 3) ? -1 : 0);
            ny = body[0].y + ((m_pend == 2) ? 1 : (m_pend == 0) ? -1 : 0);
            m_last = m_pend;
            ge  = m_gp || grow;
            hit = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
            lim = ge ? body.size() : body.size() - 1;
            for (int k = 0; k < lim; k++)
                if (body[k].x == nx && body[k].y == ny) hit = 1;
            if (hit) begin
                m_dead = 1; exp_died = 1;
                if (grow) m_gp = 1;
            end else begin
                full = body.size() >= TB_MAX;
                np.x = nx; np.y = ny;
                body.push_front(np);
                if (!ge || full) begin
                    vac = body.pop_back();
                    vac_ok = 1;
                end
                exp_mt = 1;
                if (ge) m_gp = 0;
            end
        end else if (grow) begin
            m_gp = 1;
        end
        m_pend = new_pend;
    endtask

    task automatic tick();
        int sel, qx, qy, idx;
        model_edge();
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        grow      = 1'b0;
        sel = $urandom % 4;
        if (sel < 2) begin
            idx = $urandom_range(0, body.size() - 1);
            qx = body[idx].x; qy = body[idx].y;
        end else if (sel == 2 && vac_ok) begin
            qx = vac.x; qy = vac.y;
        end else begin
            qx = $urandom_range(0, GW - 1); qy = $urandom_range(0, GH - 1);
        end
        query_x = 6'(qx);
        query_y = 5'(qy);
        #1;
        check("head_x",    head_x,    body[0].x);
        check("head_y",    head_y,    body[0].y);
        check("length",    length,    body.size());
        check("died",      died,      exp_died);
        check("move_tick", move_tick, exp_mt);
        check("query_hit", query_hit, model_hit(qx, qy));
    endtask

    // Optional key on the first cycle, optional grow on the step cycle, run to the step.
    task automatic step_with(input int code, input bit do_grow);
        if (code >= 0) begin
            key_valid = 1'b1;
            key_code  = 8'(code);
        end
        for (int n = 0; n < TB_TICK + 2; n++) begin
            if (do_grow && m_cnt == TB_TICK - 1) grow = 1'b1;
            tick();
            if (m_stepped) break;
        end
        check("step_seen", move_tick | died, 1);
    endtask

    task automatic probe(input string tag, input int qx, input int qy, input int exp);
        query_x = 6'(qx);
        query_y = 5'(qy);
        #1;
        check(tag, query_hit, exp);
    endtask

    task automatic do_init();
        init_snake = 1'b1;
        tick();
        init_snake = 1'b0;
    endtask

    initial begin
        int dead_run;
        rst_n = 1'b0; init_snake = 1'b0; screen_pause = 1'b0;
        key_valid = 1'b0; key_code = 8'h00; grow = 1'b0;
        query_x = '0; query_y = '0;

        // Reset state
        tick(); tick();
        check("rst_head_x", head_x, 20);
        check("rst_head_y", head_y, 15);
        check("rst_length", length, 3);
        probe("rst_hit_tail", 18, 15, 1);
        probe("rst_miss_beyond", 17, 15, 0);
        rst_n = 1'b1;

        // First step after four unpaused cycles
        repeat (4) tick();
        check("first_mt",   move_tick, 1);
        check("first_hx",   head_x, 21);
        check("first_len",  length, 3);
        probe("first_vacated", 18, 15, 0);

        // Reverse key ignored, then a turn
        step_with(8'h1C, 0);
        check("rev_ignored_hx", head_x, 22);
        step_with(8'h1B, 0);
        check("turn_down_hx", head_x, 22);
        check("turn_down_hy", head_y, 16);

        // Wall collision at the right edge
        do_init();
        repeat (19) step_with(-1, 0);
        check("wall_edge_hx", head_x, 39);
        step_with(-1, 0);
        check("wall_died", died, 1);
        check("wall_hold_hx", head_x, 39);
        repeat (8) tick();
        check("wall_quiet_hx", head_x, 39);
        do_init();
        check("reinit_hx",  head_x, 20);
        check("reinit_len", length, 3);

        // Growth and saturation
        step_with(-1, 1);
        check("grow_len4", length, 4);
        repeat (13) step_with(-1, 1);
        check("grow_sat16", length, 16);

        // Pause mid-count
        do_init();
        tick(); tick();
        screen_pause = 1'b1;
        repeat (10) tick();
        check("pause_hold_hx", head_x, 20);
        screen_pause = 1'b0;
        tick(); tick();
        check("unpause_step_hx", head_x, 21);

        // Self collision with a length-5 body
        do_init();
        step_with(-1, 1);
        step_with(-1, 1);
        check("self_len5", length, 5);
        step_with(8'h1B, 0);
        step_with(8'h1C, 0);
        check("self_pre_died", died, 0);
        step_with(8'h1D, 0);
        check("self_died", died, 1);

        // Reset while dead
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_dead_hx",   head_x, 20);
        check("rst_dead_len",  length, 3);
        check("rst_dead_died", died, 0);

        // Random play
        dead_run = 0;
        for (int c = 0; c < 900; c++) begin
            int r;
            init_snake = 1'b0;
            rst_n      = ($urandom % 250) != 0;
            r = $urandom % 100;
            if (r < 25) begin
                key_valid = 1'b1;
                case ($urandom % 5)
                    0:       key_code = 8'h1D;
                    1:       key_code = 8'h23;
                    2:       key_code = 8'h1B;
                    3:       key_code = 8'h1C;
                    default: key_code = 8'($urandom);
                endcase
            end
            if ($urandom % 6 == 0) grow = 1'b1;
            if ($urandom % 40 == 0) screen_pause = !screen_pause;
            dead_run = m_dead ? dead_run + 1 : 0;
            if (dead_run > 6) init_snake = 1'b1;
            tick();
        end
        rst_n = 1'b1; init_snake = 1'b0; screen_pause = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
